// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch unit. Takes a PC from writeback, reads one word
//            from instruction memory and hands the word with its PC to decode.
// Revision : 1.0  initial release
// ============================================================================
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic        BOOT_FETCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid,
    input  logic [31:0] pc_in,
    output logic        pc_ready,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    input  logic        mem_resp_err,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        inst_ready
);

    localparam logic [2:0] S_BOOT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;
    localparam logic [2:0] S_RST  = BOOT_FETCH ? S_BOOT : S_IDLE;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_fault_q, inst_fault_d;

    logic        pc_misaligned;
    assign pc_misaligned = (pc_in[1:0] != 2'b00);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_RST;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_IDLE: begin
                if (pc_valid) begin
                    state_d = pc_misaligned ? S_OUT : S_REQ;
                end
            end
            S_REQ:  if (mem_req_ready)  state_d = S_WAIT;
            S_WAIT: if (mem_resp_valid) state_d = S_OUT;
            S_OUT:  if (inst_ready)     state_d = S_IDLE;
            default: state_d = S_RST;
        endcase
    end

    // Datapath capture: misaligned PCs short-circuit straight to a fault result
    always_comb begin
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        case (state_q)
            S_BOOT: pc_d = RESET_PC;
            S_IDLE: begin
                if (pc_valid) begin
                    pc_d = pc_in;
                    if (pc_misaligned) begin
                        inst_d       = 32'h0;
                        inst_pc_d    = pc_in;
                        inst_fault_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    inst_d       = mem_resp_err ? 32'h0 : mem_resp_rdata;
                    inst_pc_d    = pc_q;
                    inst_fault_d = mem_resp_err;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state or taken from registers only
    always_comb begin
        pc_ready      = (state_q == S_IDLE);
        mem_req_valid = (state_q == S_REQ);
        mem_req_addr  = (state_q == S_REQ) ? pc_q : 32'h0;
        inst_valid    = (state_q == S_OUT);
        inst          = inst_q;
        inst_pc       = inst_pc_q;
        inst_fault    = inst_fault_q;
    end

endmodule
`default_nettype wire
